// File: rtl/hdmi_pkg.sv
// Field widths and pack layout for the delayed HDMI pixel stream, shared with unpack logic.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package hdmi_pkg;

    localparam int COLOR_W = 8;
    localparam int CTRL_W  = 4;
    localparam int PIX_W   = 3 * COLOR_W;

    // Bit offsets above the x/y region; the y field sits at bit 0 and x directly above it.
    localparam int OFS_B     = 0;
    localparam int OFS_G     = OFS_B + COLOR_W;
    localparam int OFS_R     = OFS_G + COLOR_W;
    localparam int OFS_DE    = OFS_R + COLOR_W;
    localparam int OFS_VSYNC = OFS_DE + 1;
    localparam int OFS_HSYNC = OFS_VSYNC + 1;
    localparam int OFS_CLK   = OFS_HSYNC + 1;

    function automatic int pack_width(input int xw, input int yw);
        return PIX_W + CTRL_W + xw + yw;
    endfunction

endpackage

// File: rtl/hdmi_pack_delay_shift_delay.sv
// Synchronous-reset register chain; DELAY=0 degenerates to a wire.
// Latency: DELAY cycles.
// Backpressure: none, advances every cycle.
module shift_delay #(
    parameter int DELAY = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DELAY == 0) begin : g_wire
            assign o_data = i_data;
        end else begin : g_chain
            logic [WIDTH-1:0] stage [DELAY];

            // Shift one stage per cycle; reset clears every stage so nothing in flight survives.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DELAY; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= i_data;
                    for (int i = 1; i < DELAY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign o_data = stage[DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/hdmi_pack_delay.sv
// Delays HDMI timing/colour/coordinates by DELAY cycles and packs them; o_re is de one cycle early.
// Latency: DELAY cycles for pack fields, DELAY-1 for o_re; pack clk bit is combinational.
// Backpressure: none. Build option HDMI_PACK_DELAY_XY_EN enables the x/y delay path (else x/y read 0).
module hdmi_pack_delay
    import hdmi_pkg::*;
#(
    parameter int H_ACT = 1280,
    parameter int V_ACT = 720,
    parameter int DELAY = 5,
    localparam int XW   = $clog2(H_ACT),
    localparam int YW   = $clog2(V_ACT),
    localparam int PW   = pack_width(XW, YW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_hsync,
    input  logic          i_vsync,
    input  logic          i_de,
    input  logic [7:0]    i_r,
    input  logic [7:0]    i_g,
    input  logic [7:0]    i_b,
    input  logic [XW-1:0] i_x,
    input  logic [YW-1:0] i_y,
    output logic          o_re,
    output logic [PW-1:0] pack
);

    localparam int BASE = XW + YW;

    logic [PIX_W-1:0] rgb_d;
    logic [1:0]       sync_d;
    logic             de_d;
    logic [XW-1:0]    x_d;
    logic [YW-1:0]    y_d;

    shift_delay #(.DELAY(DELAY), .WIDTH(PIX_W)) u_rgb (
        .clk    (clk),
        .rst    (rst),
        .i_data ({i_r, i_g, i_b}),
        .o_data (rgb_d)
    );

    shift_delay #(.DELAY(DELAY), .WIDTH(2)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_data ({i_hsync, i_vsync}),
        .o_data (sync_d)
    );

    // Early enable runs one stage short so downstream fetch logic gets a cycle of lead time.
    shift_delay #(.DELAY(DELAY - 1), .WIDTH(1)) u_re (
        .clk    (clk),
        .rst    (rst),
        .i_data (i_de),
        .o_data (o_re)
    );

    // Packed de is derived from o_re so the two can never drift apart by more than one cycle.
    shift_delay #(.DELAY(1), .WIDTH(1)) u_de (
        .clk    (clk),
        .rst    (rst),
        .i_data (o_re),
        .o_data (de_d)
    );

`ifdef HDMI_PACK_DELAY_XY_EN
    shift_delay #(.DELAY(DELAY), .WIDTH(XW + YW)) u_xy (
        .clk    (clk),
        .rst    (rst),
        .i_data ({i_x, i_y}),
        .o_data ({x_d, y_d})
    );
`else
    // Coordinates are not carried in this build; fields stay zero so the pack layout is unchanged.
    logic unused_xy;
    assign unused_xy = ^{i_x, i_y};
    assign x_d       = '0;
    assign y_d       = '0;
`endif

    assign pack[BASE + OFS_CLK]                   = clk;
    assign pack[BASE + OFS_HSYNC]                 = sync_d[1];
    assign pack[BASE + OFS_VSYNC]                 = sync_d[0];
    assign pack[BASE + OFS_DE]                    = de_d;
    assign pack[BASE + OFS_R +: COLOR_W]          = rgb_d[2*COLOR_W +: COLOR_W];
    assign pack[BASE + OFS_G +: COLOR_W]          = rgb_d[COLOR_W +: COLOR_W];
    assign pack[BASE + OFS_B +: COLOR_W]          = rgb_d[0 +: COLOR_W];
    assign pack[YW +: XW]                         = x_d;
    assign pack[0 +: YW]                          = y_d;

endmodule

// File: tb/tb_hdmi_pack_delay.sv
// Directed bench for hdmi_pack_delay: DELAY=5 main instance plus a DELAY=1 boundary instance.
// Inputs driven 1 time unit after the rising edge; outputs sampled there or on the falling edge.
// Pack layout (H_ACT=1280, V_ACT=720): clk 48, hs 47, vs 46, de 45, r 44:37, g 36:29, b 28:21, x 20:10, y 9:0.
module tb_hdmi_pack_delay;

    logic        clk = 1'b0;
    logic        rst;
    logic        hs, vs, de;
    logic [7:0]  r, g, b;
    logic [10:0] x;
    logic [9:0]  y;
    logic        o_re, o_re1;
    logic [48:0] pack, pack1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hdmi_pack_delay #(.H_ACT(1280), .V_ACT(720), .DELAY(5)) dut (
        .clk(clk), .rst(rst), .i_hsync(hs), .i_vsync(vs), .i_de(de),
        .i_r(r), .i_g(g), .i_b(b), .i_x(x), .i_y(y), .o_re(o_re), .pack(pack)
    );

    hdmi_pack_delay #(.H_ACT(1280), .V_ACT(720), .DELAY(1)) dut1 (
        .clk(clk), .rst(rst), .i_hsync(hs), .i_vsync(vs), .i_de(de),
        .i_r(r), .i_g(g), .i_b(b), .i_x(x), .i_y(y), .o_re(o_re1), .pack(pack1)
    );

    typedef struct {
        logic        hs, vs, de;
        logic [7:0]  r, g, b;
        logic [10:0] x;
        logic [9:0]  y;
        logic [10:0] ex;
        logic [9:0]  ey;
    } vec_t;

    localparam int NV = 6;
    vec_t tbl [NV];
    vec_t zero_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        hs = v.hs; vs = v.vs; de = v.de;
        r = v.r; g = v.g; b = v.b; x = v.x; y = v.y;
    endtask

    function automatic vec_t at(input int i);
        if (i < 0 || i >= NV) return zero_v;
        return tbl[i];
    endfunction

    // Compare every field of the DELAY=5 pack against an expected record (sampled while clk is high).
    task automatic chk_pack(input string tag, input vec_t e);
        chk({tag, ".clk"}, 32'(pack[48]), 32'd1);
        chk({tag, ".hs"},  32'(pack[47]), 32'(e.hs));
        chk({tag, ".vs"},  32'(pack[46]), 32'(e.vs));
        chk({tag, ".de"},  32'(pack[45]), 32'(e.de));
        chk({tag, ".r"},   32'(pack[44:37]), 32'(e.r));
        chk({tag, ".g"},   32'(pack[36:29]), 32'(e.g));
        chk({tag, ".b"},   32'(pack[28:21]), 32'(e.b));
        chk({tag, ".x"},   32'(pack[20:10]), 32'(e.ex));
        chk({tag, ".y"},   32'(pack[9:0]),   32'(e.ey));
    endtask

    initial begin
        vec_t v;
        zero_v = '{hs:0, vs:0, de:0, r:0, g:0, b:0, x:0, y:0, ex:0, ey:0};

`ifdef HDMI_PACK_DELAY_XY_EN
        tbl[0] = '{hs:1, vs:0, de:1, r:8'h12, g:8'h34, b:8'h56, x:11'd1279, y:10'd719, ex:11'd1279, ey:10'd719};
        tbl[1] = '{hs:0, vs:1, de:0, r:8'hFF, g:8'h00, b:8'h80, x:11'd100,  y:10'd50,  ex:11'd100,  ey:10'd50};
        tbl[2] = '{hs:1, vs:1, de:1, r:8'h01, g:8'h02, b:8'h03, x:11'd0,    y:10'd1,   ex:11'd0,    ey:10'd1};
        tbl[3] = '{hs:0, vs:0, de:1, r:8'hAA, g:8'h55, b:8'hC3, x:11'd2047, y:10'd1023,ex:11'd2047, ey:10'd1023};
        tbl[4] = '{hs:1, vs:0, de:0, r:8'h7F, g:8'hFE, b:8'h01, x:11'd640,  y:10'd360, ex:11'd640,  ey:10'd360};
        tbl[5] = '{hs:0, vs:1, de:1, r:8'h80, g:8'h81, b:8'h82, x:11'd1,    y:10'd0,   ex:11'd1,    ey:10'd0};
`else
        tbl[0] = '{hs:1, vs:0, de:1, r:8'h12, g:8'h34, b:8'h56, x:11'd1279, y:10'd719, ex:11'd0, ey:10'd0};
        tbl[1] = '{hs:0, vs:1, de:0, r:8'hFF, g:8'h00, b:8'h80, x:11'd100,  y:10'd50,  ex:11'd0, ey:10'd0};
        tbl[2] = '{hs:1, vs:1, de:1, r:8'h01, g:8'h02, b:8'h03, x:11'd0,    y:10'd1,   ex:11'd0, ey:10'd0};
        tbl[3] = '{hs:0, vs:0, de:1, r:8'hAA, g:8'h55, b:8'hC3, x:11'd2047, y:10'd1023,ex:11'd0, ey:10'd0};
        tbl[4] = '{hs:1, vs:0, de:0, r:8'h7F, g:8'hFE, b:8'h01, x:11'd640,  y:10'd360, ex:11'd0, ey:10'd0};
        tbl[5] = '{hs:0, vs:1, de:1, r:8'h80, g:8'h81, b:8'h82, x:11'd1,    y:10'd0,   ex:11'd0, ey:10'd0};
`endif

        // Reset state
        rst = 1'b1;
        drive(zero_v);
        step();
        step();
        chk_pack("reset", zero_v);
        chk("reset.o_re", 32'(o_re), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) step();

        // Single-cycle red pulse: appears at exactly the fifth edge, o_re untouched
        for (int k = 0; k < 9; k++) begin
            r = (k == 0) ? 8'hA5 : 8'h00;
            step();
            chk($sformatf("lat.r[%0d]", k), 32'(pack[44:37]), (k == 4) ? 32'hA5 : 32'h0);
            chk($sformatf("lat.o_re[%0d]", k), 32'(o_re), 32'd0);
        end

        // Early enable: de high for 10 drives -> o_re high after steps 3..12, pack de after 4..13
        for (int k = 0; k < 16; k++) begin
            de = (k < 10);
            step();
            chk($sformatf("early.o_re[%0d]", k), 32'(o_re), (k >= 3 && k <= 12) ? 32'd1 : 32'd0);
            chk($sformatf("early.de[%0d]", k), 32'(pack[45]), (k >= 4 && k <= 13) ? 32'd1 : 32'd0);
        end

        // Table: back-to-back vectors, pack shows entry k-4 and o_re shows entry k-3 after step k
        for (int k = 0; k < NV + 5; k++) begin
            drive(at(k));
            step();
            v = at(k - 4);
            chk_pack($sformatf("tbl[%0d]", k), v);
            v = at(k - 3);
            chk($sformatf("tbl.o_re[%0d]", k), 32'(o_re), 32'(v.de));
        end

        // Reset flush: preload all-ones, one reset cycle clears everything mid-flight
        v = '{hs:1, vs:1, de:1, r:8'hFF, g:8'hFF, b:8'hFF, x:11'h7FF, y:10'h3FF, ex:0, ey:0};
        drive(v);
        for (int k = 0; k < 6; k++) step();
        chk("flush.pre.r", 32'(pack[44:37]), 32'hFF);
        chk("flush.pre.o_re", 32'(o_re), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_pack("flush", zero_v);
        chk("flush.o_re", 32'(o_re), 32'd0);
        for (int k = 0; k < 6; k++) begin
            drive(zero_v);
            if (k == 0) begin
                r  = 8'h3C;
                de = 1'b1;
            end
            step();
            chk($sformatf("flush.r[%0d]", k), 32'(pack[44:37]), (k == 4) ? 32'h3C : 32'h0);
            chk($sformatf("flush.o_re[%0d]", k), 32'(o_re), (k == 3) ? 32'd1 : 32'd0);
        end

        // pack clk bit follows clk while low as well
        @(negedge clk);
        #1;
        chk("clkbit.low", 32'(pack[48]), 32'd0);
        chk("clkbit1.low", 32'(pack1[48]), 32'd0);

        // DELAY=1: o_re is i_de combinationally, packed de one cycle later
        drive(zero_v);
        step();
        step();
        de = 1'b1;
        #1;
        chk("d1.o_re.rise", 32'(o_re1), 32'd1);
        chk("d1.de.before", 32'(pack1[45]), 32'd0);
        step();
        chk("d1.de.rise", 32'(pack1[45]), 32'd1);
        de = 1'b0;
        #1;
        chk("d1.o_re.fall", 32'(o_re1), 32'd0);
        chk("d1.de.hold", 32'(pack1[45]), 32'd1);
        step();
        chk("d1.de.fall", 32'(pack1[45]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
